pc_sequencer: RTL

Fetch-side controller that owns the program counter and decides its next value every cycle: sequential increment, branch/jump redirect, trap entry, stall hold, load-use bubble insertion and halt. It sits in front of instruction memory and the IF/ID pipeline register. It drives the fetch address and a fetch-valid qualifier, and pulses the flush that kills wrong-path instructions after a redirect.

---
 rtl/pc_seq_pkg.sv | 22 ++
 rtl/pc_next_sel.sv | 48 ++++
 rtl/pc_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the fetch-side program counter sequencer.
package pc_seq_pkg;

   localparam int INSTR_BYTES = 4;
   localparam int CNT_W       = 3;

   typedef enum logic [2:0] {
      ST_RESET_HOLD,
      ST_RUN,
      ST_BUBBLE,
      ST_FLUSH,
      ST_HALT
   } pc_seq_state_t;

   typedef enum logic [1:0] {
      RD_NONE,
      RD_TRAP,
      RD_JUMP,
      RD_BRANCH
   } redirect_src_t;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC selection: redirect priority (Trap > Jump > Branch),
// misaligned-target check, and sequential increment or hold.
module pc_next_sel
   import pc_seq_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR = 32'h0000_0100
) (
   input  logic [DATA_WIDTH-1:0] pc_i,
   input  logic                  hold_i,
   input  logic                  trap_i,
   input  logic                  jump_i,
   input  logic [DATA_WIDTH-1:0] jump_target_i,
   input  logic                  branch_i,
   input  logic [DATA_WIDTH-1:0] branch_target_i,
   output logic [DATA_WIDTH-1:0] next_pc_o,
   output redirect_src_t         src_o,
   output logic                  misaligned_o
);

   always_comb begin
      src_o        = RD_NONE;
      misaligned_o = 1'b0;
      next_pc_o    = hold_i ? pc_i : pc_i + DATA_WIDTH'(INSTR_BYTES);
      if (trap_i) begin
         src_o     = RD_TRAP;
         next_pc_o = TRAP_VECTOR;
      end else if (jump_i) begin
         src_o = RD_JUMP;
         // A misaligned target becomes a trap entry rather than a bad fetch.
         if (|jump_target_i[1:0]) begin
            misaligned_o = 1'b1;
            next_pc_o    = TRAP_VECTOR;
         end else begin
            next_pc_o = jump_target_i;
         end
      end else if (branch_i) begin
         src_o = RD_BRANCH;
         if (|branch_target_i[1:0]) begin
            misaligned_o = 1'b1;
            next_pc_o    = TRAP_VECTOR;
         end else begin
            next_pc_o = branch_target_i;
         end
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// Program counter sequencer: owns the fetch PC, redirects, bubbles, flush and halt.
// Optional macro PC_SEQ_PERF_EN adds saturating stall/redirect performance counters.
module pc_sequencer
   import pc_seq_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH       = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR     = '0,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR      = 32'h0000_0100,
   parameter int unsigned           FLUSH_CYCLES     = 2,
   parameter int unsigned           LOAD_USE_BUBBLES = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  Stall,
   input  logic                  Load_Use,
   input  logic                  Branch_Taken,
   input  logic [DATA_WIDTH-1:0] Branch_Target,
   input  logic                  Jump,
   input  logic [DATA_WIDTH-1:0] Jump_Target,
   input  logic                  Trap,
   input  logic                  Halt,
   output logic [DATA_WIDTH-1:0] Current_PC,
   output logic                  Fetch_Valid,
   output logic                  Flush,
   output logic                  Misaligned,
   output logic                  Halted
`ifdef PC_SEQ_PERF_EN
   ,
   output logic [31:0]           Perf_Stall_Cnt,
   output logic [31:0]           Perf_Redirect_Cnt
`endif
);

   pc_seq_state_t         state_q, state_d;
   logic [DATA_WIDTH-1:0] pc_q, pc_d;
   logic [CNT_W-1:0]      flush_cnt_q, flush_cnt_d;
   logic [CNT_W-1:0]      bubble_cnt_q, bubble_cnt_d;
   logic                  fetch_valid_q, fetch_valid_d;
   logic                  flush_q, flush_d;
   logic                  misaligned_q, misaligned_d;
   logic                  halted_q, halted_d;

   logic [DATA_WIDTH-1:0] sel_pc;
   redirect_src_t         sel_src;
   logic                  sel_mis;
   logic                  evt_en;
   logic                  redirect;

   pc_next_sel #(
      .DATA_WIDTH  (DATA_WIDTH),
      .TRAP_VECTOR (TRAP_VECTOR)
   ) u_next_sel (
      .pc_i            (pc_q),
      .hold_i          (Stall),
      .trap_i          (Trap),
      .jump_i          (Jump),
      .jump_target_i   (Jump_Target),
      .branch_i        (Branch_Taken),
      .branch_target_i (Branch_Target),
      .next_pc_o       (sel_pc),
      .src_o           (sel_src),
      .misaligned_o    (sel_mis)
   );

   // Inputs are only honoured in the active states; RESET_HOLD and HALT ignore them.
   assign evt_en   = (state_q == ST_RUN) || (state_q == ST_BUBBLE) || (state_q == ST_FLUSH);
   assign redirect = evt_en && (sel_src != RD_NONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_RESET_HOLD;
         pc_q          <= RESET_VECTOR;
         flush_cnt_q   <= '0;
         bubble_cnt_q  <= '0;
         fetch_valid_q <= 1'b0;
         flush_q       <= 1'b0;
         misaligned_q  <= 1'b0;
         halted_q      <= 1'b0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         flush_cnt_q   <= flush_cnt_d;
         bubble_cnt_q  <= bubble_cnt_d;
         fetch_valid_q <= fetch_valid_d;
         flush_q       <= flush_d;
         misaligned_q  <= misaligned_d;
         halted_q      <= halted_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      flush_cnt_d  = flush_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      case (state_q)
         ST_RESET_HOLD: state_d = ST_RUN;
         ST_HALT:       state_d = ST_HALT;
         ST_RUN, ST_BUBBLE, ST_FLUSH: begin
            if (redirect) begin
               pc_d         = sel_pc;
               state_d      = ST_FLUSH;
               flush_cnt_d  = CNT_W'(FLUSH_CYCLES);
               bubble_cnt_d = '0;
            end else if (Halt) begin
               state_d = ST_HALT;
            end else if (Load_Use && (state_q != ST_FLUSH)) begin
               state_d      = ST_BUBBLE;
               bubble_cnt_d = CNT_W'(LOAD_USE_BUBBLES);
            end else if (state_q == ST_BUBBLE) begin
               bubble_cnt_d = bubble_cnt_q - CNT_W'(1);
               if (bubble_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
            end else begin
               // sel_pc already holds the PC when Stall is high.
               pc_d = sel_pc;
               if (state_q == ST_FLUSH) begin
                  flush_cnt_d = flush_cnt_q - CNT_W'(1);
                  if (flush_cnt_q <= CNT_W'(1)) state_d = ST_RUN;
               end
            end
         end
         default: state_d = ST_RESET_HOLD;
      endcase
   end

   // Outputs are registered, so they decode the state being entered.
   always_comb begin
      fetch_valid_d = (state_d == ST_RUN) || (state_d == ST_FLUSH);
      flush_d       = (state_d == ST_FLUSH);
      halted_d      = (state_d == ST_HALT);
      misaligned_d  = redirect && sel_mis;
   end

   assign Current_PC  = pc_q;
   assign Fetch_Valid = fetch_valid_q;
   assign Flush       = flush_q;
   assign Misaligned  = misaligned_q;
   assign Halted      = halted_q;

`ifdef PC_SEQ_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] redir_cnt_q, redir_cnt_d;
   logic        stall_active;

   assign stall_active = (state_q == ST_BUBBLE) || (Stall && evt_en);

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      redir_cnt_d = redir_cnt_q;
      if (stall_active && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
      if (redirect && (redir_cnt_q != '1))     redir_cnt_d = redir_cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt_q <= '0;
         redir_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         redir_cnt_q <= redir_cnt_d;
      end
   end

   assign Perf_Stall_Cnt    = stall_cnt_q;
   assign Perf_Redirect_Cnt = redir_cnt_q;
`endif

endmodule
